fl32_add: RTL and testbench

- IEEE-754 binary32 floating-point adder for the GPU datapath.
- Computes the sum of two single-precision operands, including signed operands (subtraction via sign).
- Combinational add core with one output register stage.
- Sits in the shader ALU as the FP add unit.

---
 rtl/fl32_add.sv | 125 ++++++++++++
 tb/tb_fl32_add.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fl32_add.sv
// rtl/fl32_add.sv - binary32 adder, one output register stage; FL32_DENORM_EN enables subnormals
module fl32_add (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_0,
    input  logic [31:0] in_1,
    output logic [31:0] out,
    output logic        out_valid
);
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        swap, eff_sub, inc, flush, sign;
    logic [31:0] l, s, core, res;
    logic [7:0]  l_exp, s_exp, d;
    logic [23:0] l_sig, s_sig;
    logic [49:0] wide;
    logic [26:0] s_al, m;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  e;
    logic [30:0] rnd;
`ifdef FL32_DENORM_EN
    logic [4:0]  sh;
`endif

    assign a_nan = (&in_0[30:23]) && (|in_0[22:0]);
    assign b_nan = (&in_1[30:23]) && (|in_1[22:0]);
    assign a_inf = (&in_0[30:23]) && !(|in_0[22:0]);
    assign b_inf = (&in_1[30:23]) && !(|in_1[22:0]);
`ifdef FL32_DENORM_EN
    assign a_zero = ~|in_0[30:0];
    assign b_zero = ~|in_1[30:0];
`else
    assign a_zero = ~|in_0[30:23];
    assign b_zero = ~|in_1[30:23];
`endif
    assign swap = (b_zero ? 31'd0 : in_1[30:0]) > (a_zero ? 31'd0 : in_0[30:0]);

    always_comb begin
        flush   = 1'b0;
        l       = swap ? in_1 : in_0;
        s       = swap ? in_0 : in_1;
        l_exp   = (l[30:23] == 8'd0) ? 8'd1 : l[30:23];
        s_exp   = (s[30:23] == 8'd0) ? 8'd1 : s[30:23];
        l_sig   = {|l[30:23], l[22:0]};
        s_sig   = {|s[30:23], s[22:0]};
        d       = l_exp - s_exp;
        // 26 spare low bits catch everything shifted out; they fold into sticky
        wide    = {s_sig, 26'd0} >> d;
        s_al    = (d >= 8'd26) ? {26'd0, |s_sig} : {wide[49:24], |wide[23:0]};
        eff_sub = l[31] ^ s[31];
        sign    = l[31];
        sum     = eff_sub ? ({1'b0, l_sig, 3'd0} - {1'b0, s_al})
                          : ({1'b0, l_sig, 3'd0} + {1'b0, s_al});
        lz      = lzc27(sum[26:0]);
        if (sum[27]) begin
            m = {sum[27:2], sum[1] | sum[0]};
            e = {2'd0, l_exp} + 10'd1;
        end else begin
`ifdef FL32_DENORM_EN
            // stop normalising at the minimum exponent; leftovers are subnormal
            sh = ({5'd0, lz} < {2'd0, l_exp}) ? lz : 5'(l_exp - 8'd1);
            m  = sum[26:0] << sh;
            e  = {2'd0, l_exp} - {5'd0, sh};
            if (!m[26])
                e = 10'd0;
`else
            m     = sum[26:0] << lz;
            e     = {2'd0, l_exp} - {5'd0, lz};
            flush = ({5'd0, lz} >= {2'd0, l_exp});
`endif
        end
        inc = m[2] & (m[1] | m[0] | m[3]);
        // carry out of the fraction ripples into the exponent field
        rnd = {e[7:0], m[25:3]} + {30'd0, inc};
        if (sum == 28'd0)
            core = 32'h0000_0000;
        else if (flush)
            core = {sign, 31'd0};
        else if (e >= 10'd255)
            core = {sign, 8'hFF, 23'd0};
        else
            core = {sign, rnd};

        if (a_nan || b_nan || (a_inf && b_inf && (in_0[31] != in_1[31])))
            res = 32'h7FC0_0000;
        else if (a_inf)
            res = in_0;
        else if (b_inf)
            res = in_1;
        else if (a_zero && b_zero)
            res = {in_0[31] & in_1[31], 31'd0};
        else if (b_zero)
            res = in_0;
        else if (a_zero)
            res = in_1;
        else
            res = core;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= 32'h0000_0000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                out <= res;
        end
    end
endmodule

// File: tb/tb_fl32_add.sv
// tb/tb_fl32_add.sv - randomized bench for fl32_add against a real-arithmetic reference model
module tb_fl32_add;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_0, in_1;
    logic [31:0] out;
    logic        out_valid;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_out;
    logic        exp_v;

    fl32_add dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_0      (in_0),
        .in_1      (in_1),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic real f2r(input logic [31:0] x);
        real r;
        logic [10:0] e11;
        if (x[30:23] == 8'd0) begin
`ifdef FL32_DENORM_EN
            r = real'(x[22:0]);
            for (int i = 0; i < 149; i++)
                r = r / 2.0;
`else
            r = 0.0;
`endif
            return x[31] ? -r : r;
        end
        e11 = {3'd0, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e11, x[22:0], 29'd0});
    endfunction

    // Double-precision sum then a single round-to-nearest-even to binary32
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic an, bn, ai, bi, az, bz;
        real s;
        logic [63:0] db;
        longint ex, sh, m, q, rem, half, bits, one;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
`ifdef FL32_DENORM_EN
        az = (a[30:0] == 0);
        bz = (b[30:0] == 0);
`else
        az = (a[30:23] == 0);
        bz = (b[30:23] == 0);
`endif
        if (an || bn) return 32'h7FC00000;
        if (ai && bi && (a[31] != b[31])) return 32'h7FC00000;
        if (ai) return a;
        if (bi) return b;
        if (az && bz) return (a[31] && b[31]) ? 32'h80000000 : 32'h00000000;
        if (bz) return a;
        if (az) return b;
        s = f2r(a) + f2r(b);
        if (s == 0.0) return 32'h00000000;
        db = $realtobits(s);
        ex = longint'(db[62:52]) - 1023;
        m  = longint'({12'd1, db[51:0]});
`ifndef FL32_DENORM_EN
        if (ex < -126) return {db[63], 31'd0};
`endif
        sh = 29;
        if (ex < -126) sh = 29 + (-126 - ex);
        if (sh > 60) sh = 60;
        one  = 1;
        q    = m >> sh;
        rem  = m & ((one << sh) - 1);
        half = one << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        bits = (ex >= -126) ? (((ex + 126) << 23) + q) : q;
        if (bits >= 64'h7F800000) return {db[63], 31'h7F800000};
        return {db[63], bits[30:0]};
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic use_fixed, input logic [31:0] fixed);
        rst = r; in_valid = v; in_0 = a; in_1 = b;
        @(posedge clk);
        #1;
        if (r) begin
            exp_v = 1'b0; exp_out = 32'h0;
        end else begin
            exp_v = v;
            if (v) exp_out = use_fixed ? fixed : ref_add(a, b);
        end
        chk($sformatf("out_valid r=%0b v=%0b a=%h b=%h", r, v, a, b), {31'd0, out_valid}, {31'd0, exp_v});
        chk($sformatf("out r=%0b v=%0b a=%h b=%h", r, v, a, b), out, exp_out);
    endtask

    function automatic logic [31:0] rand_op(input logic [31:0] other);
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 11))
            0: begin x[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) x[22:0] = 23'd0; end
            1: x[30:0] = 31'd0;
            2: x[30:23] = 8'd0;
            3, 4: begin x[30:23] = other[30:23] + 8'($urandom_range(0, 2)) - 8'd1; x[31] = ~other[31]; end
            5: x[30:23] = 8'hFE - 8'($urandom_range(0, 1));
            6: begin x = other ^ 32'h80000000; x[3:0] = 4'($urandom); end
            7: x[30:23] = 8'($urandom_range(0, 3));
            8: x[30:23] = other[30:23] - 8'($urandom_range(20, 30));
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        logic [31:0] a, b;
        // reset asserted together with a valid operation
        cycle(1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h3F800000, 32'h40000000, 1'b1, 32'h40400000);
        cycle(1'b0, 1'b1, 32'h3FC00000, 32'h40200000, 1'b1, 32'h40800000);
        cycle(1'b0, 1'b1, 32'hBF800000, 32'hC0000000, 1'b1, 32'hC0400000);
        cycle(1'b0, 1'b1, 32'h40000000, 32'hC0000000, 1'b1, 32'h00000000);
        cycle(1'b0, 1'b1, 32'h40A00000, 32'hC0000000, 1'b1, 32'h40400000);
        cycle(1'b0, 1'b1, 32'h40400000, 32'h00000000, 1'b1, 32'h40400000);
        cycle(1'b0, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000);
        cycle(1'b0, 1'b1, 32'h80000000, 32'h80000000, 1'b1, 32'h80000000);
        cycle(1'b0, 1'b1, 32'h52968000, 32'h3F800000, 1'b1, 32'h52968000);
        cycle(1'b0, 1'b1, 32'h40000000, 32'h40000000, 1'b1, 32'h40800000);
        cycle(1'b0, 1'b1, 32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000);
        cycle(1'b0, 1'b1, 32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000);
        cycle(1'b0, 1'b1, 32'h7F800000, 32'hFF800000, 1'b1, 32'h7FC00000);
        cycle(1'b0, 1'b1, 32'h7FC00000, 32'h3F800000, 1'b1, 32'h7FC00000);
        cycle(1'b0, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b1, 32'h7FC00000);
        cycle(1'b0, 1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000);
        cycle(1'b0, 1'b1, 32'h00000001, 32'h3F800000, 1'b1, 32'h3F800000);
`ifdef FL32_DENORM_EN
        cycle(1'b0, 1'b1, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002);
`else
        cycle(1'b0, 1'b1, 32'h00000001, 32'h00000001, 1'b1, 32'h00000000);
`endif
        // idle cycles hold the last result
        cycle(1'b0, 1'b0, 32'h40000000, 32'h40000000, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40800000);
        cycle(1'b1, 1'b1, 32'h40400000, 32'h3F800000, 1'b0, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            a = rand_op($urandom);
            b = rand_op(a);
            if ($urandom_range(0, 1) == 0) begin
                a = b; b = rand_op(a);
            end
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), a, b, 1'b0, 32'h0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
